// File: rtl/vend_pkg.sv
// Shared definitions for the vending machine: vend codes published by the coin
// FSM, its one-hot state constants, and the dispense sequencer state encoding.
package vend_pkg;

    localparam int COIN_STATE_W = 7;
    localparam int ERR_W        = 3;

    // Vend code carried in coin_state[6:5]
    localparam logic [1:0] VEND_NONE     = 2'b00;
    localparam logic [1:0] VEND_COLA     = 2'b01;
    localparam logic [1:0] VEND_COLA_CHG = 2'b10;
    localparam logic [1:0] VEND_ILLEGAL  = 2'b11;

    // Coin accumulation FSM one-hot states, coin_state[4:0]
    localparam logic [4:0] COIN_ST_IDLE = 5'b00001;
    localparam logic [4:0] COIN_ST_5C   = 5'b00010;
    localparam logic [4:0] COIN_ST_10C  = 5'b00100;
    localparam logic [4:0] COIN_ST_15C  = 5'b01000;
    localparam logic [4:0] COIN_ST_20C  = 5'b10000;

    // Bit positions inside err_flags
    localparam int ERR_ILLEGAL = 2;
    localparam int ERR_OVERRUN = 1;
    localparam int ERR_TIMEOUT = 0;

    // Dispense sequencer states, one-hot
    typedef enum logic [5:0] {
        ST_IDLE     = 6'b000001,
        ST_COLA_ON  = 6'b000010,
        ST_COLA_GAP = 6'b000100,
        ST_CHG_ON   = 6'b001000,
        ST_CHG_GAP  = 6'b010000,
        ST_FAULT    = 6'b100000
    } disp_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vend_dispense_ctrl_if.sv
// Signal bundle between the coin FSM / actuators and the dispense sequencer.
interface vend_dispense_ctrl_if;
    import vend_pkg::*;

    logic [COIN_STATE_W-1:0] coin_state;
    logic                    cola_done;
    logic                    change_done;
    logic                    fault_clr;
    logic                    po_cola_motor;
    logic                    po_change_motor;
    logic                    coin_inhibit;
    logic                    fault;
    logic [ERR_W-1:0]        err_flags;

    modport master (
        output coin_state, cola_done, change_done, fault_clr,
        input  po_cola_motor, po_change_motor, coin_inhibit, fault, err_flags
    );

    modport slave (
        input  coin_state, cola_done, change_done, fault_clr,
        output po_cola_motor, po_change_motor, coin_inhibit, fault, err_flags
    );

endinterface

// File: rtl/vend_timeout_cnt.sv
// Cycle timer shared by the actuator-on and settle states. It saturates at the
// terminal value instead of wrapping; the owner clears it on each state change.
module vend_timeout_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] tc_val,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    assign tc = (count == tc_val);

    // Count up while enabled, hold at terminal count, clear on request
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer: on each new vend event runs the cola motor, then the
// change ejector when owed, with done handshakes, timeouts and settle gaps.
// Inhibits coins while busy or faulted and keeps sticky error flags.
module vend_dispense_ctrl
    import vend_pkg::*;
#(
    parameter int MOTOR_TIMEOUT = 100_000_000,
    parameter int SETTLE_CYC    = 5_000_000
) (
    input logic                 sys_clk,
    input logic                 sys_rst_n,
    vend_dispense_ctrl_if.slave bus
);

    localparam int TMR_W = $clog2(max_int(MOTOR_TIMEOUT, SETTLE_CYC));
    localparam logic [TMR_W-1:0] ON_TC  = TMR_W'(MOTOR_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] GAP_TC = TMR_W'(SETTLE_CYC - 1);

    disp_state_e      state;
    disp_state_e      state_nxt;
    logic [1:0]       prev_code;
    logic             armed;
    logic             chg_pend;
    logic             chg_pend_nxt;
    logic [ERR_W-1:0] err_q;
    logic [ERR_W-1:0] err_nxt;
    logic [1:0]       coin_code;
    logic             trig;
    logic             timeout_set;
    logic             tmr_en;
    logic             tmr_clr;
    logic             tmr_tc;
    logic [TMR_W-1:0] tmr_tc_val;

    assign coin_code = bus.coin_state[6:5];

    // armed masks the first cycle after reset so prev_code reloads from the
    // live code first; a code held through reset is not taken as a new vend
    assign trig = armed && (prev_code == VEND_NONE) && (coin_code != VEND_NONE);

    vend_timeout_cnt #(
        .WIDTH (TMR_W)
    ) u_timer (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (tmr_clr),
        .en        (tmr_en),
        .tc_val    (tmr_tc_val),
        .tc        (tmr_tc)
    );

    // Next-state, timer control and error flag update
    always_comb begin
        state_nxt    = state;
        chg_pend_nxt = chg_pend;
        tmr_en       = 1'b0;
        tmr_tc_val   = GAP_TC;
        timeout_set  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trig && (coin_code == VEND_COLA || coin_code == VEND_COLA_CHG)) begin
                    state_nxt    = ST_COLA_ON;
                    chg_pend_nxt = (coin_code == VEND_COLA_CHG);
                end
            end
            ST_COLA_ON: begin
                tmr_en     = 1'b1;
                tmr_tc_val = ON_TC;
                if (bus.cola_done) begin
                    state_nxt = ST_COLA_GAP;
                end else if (tmr_tc) begin
                    state_nxt   = ST_FAULT;
                    timeout_set = 1'b1;
                end
            end
            ST_COLA_GAP: begin
                tmr_en = 1'b1;
                if (tmr_tc) begin
                    state_nxt = chg_pend ? ST_CHG_ON : ST_IDLE;
                end
            end
            ST_CHG_ON: begin
                tmr_en     = 1'b1;
                tmr_tc_val = ON_TC;
                if (bus.change_done) begin
                    state_nxt = ST_CHG_GAP;
                end else if (tmr_tc) begin
                    state_nxt   = ST_FAULT;
                    timeout_set = 1'b1;
                end
            end
            ST_CHG_GAP: begin
                tmr_en = 1'b1;
                if (tmr_tc) begin
                    state_nxt    = ST_IDLE;
                    chg_pend_nxt = 1'b0;
                end
            end
            ST_FAULT: begin
                if (bus.fault_clr) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        tmr_clr = (state_nxt != state);

        err_nxt = bus.fault_clr ? '0 : err_q;
        if (trig && coin_code == VEND_ILLEGAL) begin
            err_nxt[ERR_ILLEGAL] = 1'b1;
        end
        if (trig && state != ST_IDLE) begin
            err_nxt[ERR_OVERRUN] = 1'b1;
        end
        if (timeout_set) begin
            err_nxt[ERR_TIMEOUT] = 1'b1;
        end
    end

    // State, edge detector, pending-change and error flag registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= ST_IDLE;
            prev_code <= VEND_NONE;
            armed     <= 1'b0;
            chg_pend  <= 1'b0;
            err_q     <= '0;
        end else begin
            state     <= state_nxt;
            prev_code <= coin_code;
            armed     <= 1'b1;
            chg_pend  <= chg_pend_nxt;
            err_q     <= err_nxt;
        end
    end

    // Registered outputs decoded from the next state so they align with it
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bus.po_cola_motor   <= 1'b0;
            bus.po_change_motor <= 1'b0;
            bus.fault           <= 1'b0;
            bus.coin_inhibit    <= 1'b0;
            bus.err_flags       <= '0;
        end else begin
            bus.po_cola_motor   <= (state_nxt == ST_COLA_ON);
            bus.po_change_motor <= (state_nxt == ST_CHG_ON);
            bus.fault           <= (state_nxt == ST_FAULT);
            bus.coin_inhibit    <= (state_nxt != ST_IDLE) || (state_nxt == ST_FAULT);
            bus.err_flags       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Scoreboard bench for vend_dispense_ctrl. Stimulus pushes the expected output
// tuple {cola, change, inhibit, fault, err[2:0]} and how many cycles the
// previous tuple should have lasted (0 = don't care); the monitor pops on
// every output change.
module tb_vend_dispense_ctrl;
    import vend_pkg::*;

    localparam int MT = 20;
    localparam int SC = 4;

    typedef struct {
        logic [6:0] obs;
        int         dwell;
    } exp_t;

    logic sys_clk;
    logic sys_rst_n;
    vend_dispense_ctrl_if bus();

    exp_t expQ[$];
    int   checks;
    int   errors;
    logic [6:0] prevObs;
    int   dwell;

    vend_dispense_ctrl #(
        .MOTOR_TIMEOUT (MT),
        .SETTLE_CYC    (SC)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    // Free-running clock
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pushExp(input logic [6:0] obs, input int dw);
        exp_t e;
        e.obs   = obs;
        e.dwell = dw;
        expQ.push_back(e);
    endtask

    // Vend with done pulses at the given cycle of each ON state (chgAt 0 = no change)
    task automatic applyStimulus(input logic [1:0] code, input int colaAt, input int chgAt);
        bus.coin_state = {code, COIN_ST_IDLE};
        tick();
        repeat (colaAt - 1) tick();
        bus.cola_done = 1'b1;
        tick();
        bus.cola_done = 1'b0;
        if (chgAt > 0) begin
            repeat (SC) tick();
            repeat (chgAt - 1) tick();
            bus.change_done = 1'b1;
            tick();
            bus.change_done = 1'b0;
        end
        repeat (SC) tick();
        bus.coin_state = {VEND_NONE, COIN_ST_IDLE};
        repeat (2) tick();
    endtask

    task automatic pulseFaultClr();
        bus.fault_clr = 1'b1;
        tick();
        bus.fault_clr = 1'b0;
    endtask

    // Monitor: on each output change pop and compare the expected tuple and dwell
    always @(negedge sys_clk) begin
        logic [6:0] cur;
        exp_t       e;
        cur = {bus.po_cola_motor, bus.po_change_motor, bus.coin_inhibit, bus.fault, bus.err_flags};
        if (cur !== prevObs) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got 0x%0h, expected no change", cur);
            end else begin
                e = expQ.pop_front();
                checkOutput("output_tuple", int'(cur), int'(e.obs));
                if (e.dwell != 0) begin
                    checkOutput("prev_dwell", dwell, e.dwell);
                end
            end
            prevObs = cur;
            dwell   = 1;
        end else begin
            dwell++;
        end
    end

    initial begin
        checks          = 0;
        errors          = 0;
        prevObs         = '0;
        dwell           = 0;
        sys_rst_n       = 1'b0;
        bus.coin_state  = {VEND_NONE, COIN_ST_IDLE};
        bus.cola_done   = 1'b0;
        bus.change_done = 1'b0;
        bus.fault_clr   = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        repeat (2) tick();
        checkOutput("reset_state",
                    int'({bus.po_cola_motor, bus.po_change_motor, bus.coin_inhibit,
                          bus.fault, bus.err_flags}), 0);

        $display("[TB] cola only");
        pushExp(7'b1010000, 0);
        pushExp(7'b0010000, 5);
        pushExp(7'b0000000, SC);
        applyStimulus(VEND_COLA, 5, 0);

        $display("[TB] cola plus change");
        pushExp(7'b1010000, 0);
        pushExp(7'b0010000, 3);
        pushExp(7'b0110000, SC);
        pushExp(7'b0010000, 2);
        pushExp(7'b0000000, SC);
        applyStimulus(VEND_COLA_CHG, 3, 2);

        $display("[TB] cola timeout");
        pushExp(7'b1010000, 0);
        pushExp(7'b0011001, MT);
        pushExp(7'b0000000, 3);
        bus.coin_state = {VEND_COLA, COIN_ST_IDLE};
        tick();
        repeat (MT) tick();
        repeat (2) tick();
        pulseFaultClr();
        bus.coin_state = {VEND_NONE, COIN_ST_IDLE};
        repeat (2) tick();

        $display("[TB] overrun during cola");
        pushExp(7'b1010000, 0);
        pushExp(7'b1010010, 2);
        pushExp(7'b0010010, 4);
        pushExp(7'b0000010, SC);
        pushExp(7'b0000000, 2);
        bus.coin_state = {VEND_COLA, COIN_ST_IDLE};
        tick();
        bus.coin_state = {VEND_NONE, COIN_ST_IDLE};
        tick();
        bus.coin_state = {VEND_COLA, COIN_ST_IDLE};
        repeat (4) tick();
        bus.cola_done = 1'b1;
        tick();
        bus.cola_done = 1'b0;
        repeat (SC) tick();
        tick();
        pulseFaultClr();
        bus.coin_state = {VEND_NONE, COIN_ST_IDLE};
        repeat (2) tick();

        $display("[TB] illegal code");
        pushExp(7'b0000100, 0);
        pushExp(7'b0000000, 3);
        bus.coin_state = {VEND_ILLEGAL, COIN_ST_IDLE};
        repeat (3) tick();
        pulseFaultClr();
        bus.coin_state = {VEND_NONE, COIN_ST_IDLE};
        repeat (2) tick();

        $display("[TB] reset mid dispense");
        pushExp(7'b1010000, 0);
        pushExp(7'b0000000, 2);
        bus.coin_state = {VEND_COLA, COIN_ST_IDLE};
        repeat (3) tick();
        #2 sys_rst_n = 1'b0;
        #1 checkOutput("async_reset", int'({bus.po_cola_motor, bus.coin_inhibit}), 0);
        repeat (2) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        repeat (10) tick();
        bus.coin_state = {VEND_NONE, COIN_ST_IDLE};
        repeat (5) tick();

        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
